// File: rtl/branch_resolve_stage_if.sv
// Branch-resolve handshake and result bundle shared by the issuing stage
// (master) and the branch resolve stage (slave).
interface branch_resolve_stage_if #(
  parameter int XLEN = 64
);
  logic            in_valid;
  logic            stall;
  logic [2:0]      br_op;
  logic [XLEN-1:0] A;
  logic [XLEN-1:0] B;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] imm;
  logic            in_ready;
  logic            out_valid;
  logic            taken;
  logic [XLEN-1:0] target;
  logic            flush;
  logic            illegal;
  logic [31:0]     taken_cnt;
  logic [31:0]     total_cnt;

  modport master (
    output in_valid, stall, br_op, A, B, pc, imm,
    input  in_ready, out_valid, taken, target, flush, illegal, taken_cnt, total_cnt
  );

  modport slave (
    input  in_valid, stall, br_op, A, B, pc, imm,
    output in_ready, out_valid, taken, target, flush, illegal, taken_cnt, total_cnt
  );
endinterface

// File: rtl/branch_resolve_stage.sv
// Branch resolve stage: evaluates the branch condition, computes pc+imm,
// and after a taken branch holds a flush request to IF/ID for FLUSH_CYCLES
// cycles while dropping the wrong-path requests that arrive meanwhile.
module branch_resolve_stage #(
  parameter int XLEN         = 64,
  parameter int FLUSH_CYCLES = 2
) (
  input logic                   clk,
  input logic                   rst,
  branch_resolve_stage_if.slave bus_io
);

  typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_t;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t          state_q, state_d;
  logic [3:0]      fcnt_q, fcnt_d;
  logic            out_valid_q;
  logic            taken_q;
  logic            illegal_q;
  logic [XLEN-1:0] target_q;
  logic [31:0]     taken_cnt_q;
  logic [31:0]     total_cnt_q;

  logic signed [XLEN-1:0] a_s;
  logic signed [XLEN-1:0] b_s;
  logic            eq, lt, ltu;
  logic            op_illegal;
  logic            cond_taken;
  logic            in_ready;
  logic            capture;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Map the branch opcode onto the compare flags; illegal opcodes never take.
  function automatic logic resolve(input logic [2:0] op, input logic f_eq,
                                   input logic f_lt, input logic f_ltu);
    case (op)
      3'b000:  return f_eq;
      3'b001:  return !f_eq;
      3'b100:  return f_lt;
      3'b101:  return !f_lt;
      3'b110:  return f_ltu;
      3'b111:  return !f_ltu;
      default: return 1'b0;
    endcase
  endfunction

  // Operand compare, condition resolve and capture qualification.
  always_comb begin
    a_s        = bus_io.A;
    b_s        = bus_io.B;
    eq         = (bus_io.A == bus_io.B);
    lt         = (a_s < b_s);
    ltu        = (bus_io.A < bus_io.B);
    op_illegal = (bus_io.br_op[2:1] == 2'b01);
    cond_taken = resolve(bus_io.br_op, eq, lt, ltu);
    in_ready   = (state_q == IDLE);
    capture    = bus_io.in_valid && in_ready && !bus_io.stall;
  end

  // Next state: a taken capture opens the flush window; the counter runs
  // down regardless of stall and the window closes once it reads zero.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    if (state_q == IDLE) begin
      if (capture && cond_taken) begin
        state_d = FLUSH;
        fcnt_d  = FLUSH_LOAD;
      end
    end else begin
      if (fcnt_q == 4'd0) begin
        state_d = IDLE;
      end else begin
        fcnt_d = fcnt_q - 4'd1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      fcnt_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // Result registers: pulses every cycle, held values and counters on capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
      taken_q     <= 1'b0;
      target_q    <= '0;
      taken_cnt_q <= 32'd0;
      total_cnt_q <= 32'd0;
    end else begin
      out_valid_q <= capture;
      illegal_q   <= capture && op_illegal;
      if (capture) begin
        taken_q     <= cond_taken;
        target_q    <= bus_io.pc + bus_io.imm;
        total_cnt_q <= sat_inc(total_cnt_q);
        if (cond_taken) begin
          taken_cnt_q <= sat_inc(taken_cnt_q);
        end
      end
    end
  end

  assign bus_io.in_ready  = in_ready;
  assign bus_io.out_valid = out_valid_q;
  assign bus_io.taken     = taken_q;
  assign bus_io.target    = target_q;
  assign bus_io.flush     = (state_q == FLUSH);
  assign bus_io.illegal   = illegal_q;
  assign bus_io.taken_cnt = taken_cnt_q;
  assign bus_io.total_cnt = total_cnt_q;

endmodule

// File: tb/tb_branch_resolve_stage.sv
// Bench for branch_resolve_stage: directed branches push their expected
// result into a queue; a monitor pops and checks on every out_valid.
module tb_branch_resolve_stage;

  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;

  typedef struct {
    logic        taken;
    logic [63:0] target;
    logic        illegal;
    logic [31:0] tkc;
    logic [31:0] totc;
  } exp_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  exp_t q[$];
  exp_t m_e;

  branch_resolve_stage_if #(.XLEN(64)) dut_if ();

  branch_resolve_stage #(.XLEN(64), .FLUSH_CYCLES(2)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (dut_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic tk, input logic [63:0] tg, input logic il,
                          input logic [31:0] tc, input logic [31:0] tt);
    exp_t e;
    e.taken = tk; e.target = tg; e.illegal = il; e.tkc = tc; e.totc = tt;
    q.push_back(e);
  endtask

  // Present one request for one cycle; in_valid is left high for the caller.
  task automatic send(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                      input logic [63:0] p, input logic [63:0] i,
                      input logic tk, input logic [63:0] tg, input logic il,
                      input logic [31:0] tc, input logic [31:0] tt);
    dut_if.in_valid = 1'b1;
    dut_if.br_op    = op;
    dut_if.A        = a;
    dut_if.B        = b;
    dut_if.pc       = p;
    dut_if.imm      = i;
    push_exp(tk, tg, il, tc, tt);
    @(posedge clk); #1;
  endtask

  task automatic wait_ready();
    bit seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (dut_if.in_ready === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL wait_ready actual=timeout required=in_ready");
    end
    @(posedge clk); #1;
  endtask

  // Monitor: every out_valid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (dut_if.out_valid === 1'b1) begin
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_out_valid actual=1 required=0 target=%h", dut_if.target);
      end else begin
        m_e = q.pop_front();
        chk("mon_taken",   64'(dut_if.taken),     64'(m_e.taken));
        chk("mon_target",  dut_if.target,         m_e.target);
        chk("mon_illegal", 64'(dut_if.illegal),   64'(m_e.illegal));
        chk("mon_flush",   64'(dut_if.flush),     64'(m_e.taken));
        chk("mon_tkcnt",   64'(dut_if.taken_cnt), 64'(m_e.tkc));
        chk("mon_totcnt",  64'(dut_if.total_cnt), 64'(m_e.totc));
      end
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    dut_if.stall = 1'b0;
    dut_if.imm   = 64'h0;
    // Reset with a legal taken BEQ presented: reset must win.
    rst = 1'b1;
    dut_if.in_valid = 1'b1;
    dut_if.br_op    = BEQ;
    dut_if.A        = 64'h0;
    dut_if.B        = 64'h0;
    dut_if.pc       = 64'h100;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    dut_if.in_valid = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(dut_if.out_valid), 64'd0);
    chk("rst_in_ready",  64'(dut_if.in_ready),  64'd1);
    chk("rst_flush",     64'(dut_if.flush),     64'd0);
    chk("rst_taken",     64'(dut_if.taken),     64'd0);
    chk("rst_target",    dut_if.target,         64'd0);
    chk("rst_illegal",   64'(dut_if.illegal),   64'd0);
    chk("rst_tkcnt",     64'(dut_if.taken_cnt), 64'd0);
    chk("rst_totcnt",    64'(dut_if.total_cnt), 64'd0);
    @(posedge clk); #1;

    // Taken BEQ: flush spans the out_valid cycle plus one more.
    send(BEQ, 64'h1111_2222_3333_4444, 64'h1111_2222_3333_4444, 64'h1000, 64'h40,
         1'b1, 64'h1040, 1'b0, 32'd1, 32'd1);
    dut_if.in_valid = 1'b0;
    @(negedge clk);
    chk("beq_c1_flush",    64'(dut_if.flush),     64'd1);
    chk("beq_c1_in_ready", 64'(dut_if.in_ready),  64'd0);
    @(negedge clk);
    chk("beq_c2_flush",    64'(dut_if.flush),     64'd1);
    chk("beq_c2_in_ready", 64'(dut_if.in_ready),  64'd0);
    chk("beq_c2_out_valid",64'(dut_if.out_valid), 64'd0);
    @(negedge clk);
    chk("beq_c3_flush",    64'(dut_if.flush),     64'd0);
    chk("beq_c3_in_ready", 64'(dut_if.in_ready),  64'd1);
    @(posedge clk); #1;

    // Signed vs unsigned compare.
    send(BLT, 64'hAAAA_BBBB_CCCC_DDDD, 64'h1111_2222_3333_4444, 64'h2000, 64'h8,
         1'b1, 64'h2008, 1'b0, 32'd2, 32'd2);
    dut_if.in_valid = 1'b0;
    wait_ready();
    // Back-to-back not-taken stream: BLTU, BGE, BNE on consecutive cycles.
    send(BLTU, 64'hAAAA_BBBB_CCCC_DDDD, 64'h1111_2222_3333_4444, 64'h3000,
         64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'h2FFC, 1'b0, 32'd2, 32'd3);
    send(BGE, 64'h0, 64'h1111_2222_3333_4554, 64'h4000, 64'h10,
         1'b0, 64'h4010, 1'b0, 32'd2, 32'd4);
    send(BNE, 64'h0, 64'h0, 64'h4004, 64'h0,
         1'b0, 64'h4004, 1'b0, 32'd2, 32'd5);
    dut_if.in_valid = 1'b0;
    @(negedge clk);
    chk("stream_in_ready", 64'(dut_if.in_ready), 64'd1);
    chk("stream_flush",    64'(dut_if.flush),    64'd0);
    @(posedge clk); #1;

    // Target wrap, then in_valid held for 3 cycles: 2 dropped, 3rd captured.
    send(BEQ, 64'h5, 64'h5, 64'hFFFF_FFFF_FFFF_FFF0, 64'h20,
         1'b1, 64'h10, 1'b0, 32'd3, 32'd6);
    dut_if.br_op = BGEU;
    dut_if.A     = 64'h3;
    dut_if.B     = 64'h3;
    dut_if.pc    = 64'h5000;
    dut_if.imm   = 64'h100;
    push_exp(1'b1, 64'h5100, 1'b0, 32'd4, 32'd7);
    repeat (3) @(posedge clk);
    #1;
    // Flush window keeps counting down under stall.
    dut_if.in_valid = 1'b0;
    dut_if.stall    = 1'b1;
    @(negedge clk);
    chk("stall_c1_flush",    64'(dut_if.flush),    64'd1);
    @(negedge clk);
    chk("stall_c2_flush",    64'(dut_if.flush),    64'd1);
    chk("stall_c2_in_ready", 64'(dut_if.in_ready), 64'd0);
    @(negedge clk);
    chk("stall_c3_flush",    64'(dut_if.flush),    64'd0);
    chk("stall_c3_in_ready", 64'(dut_if.in_ready), 64'd1);
    @(posedge clk); #1;

    // Illegal opcode held under stall: nothing captured until stall drops.
    dut_if.in_valid = 1'b1;
    dut_if.br_op    = 3'b010;
    dut_if.A        = 64'h0;
    dut_if.B        = 64'h0;
    dut_if.pc       = 64'h6000;
    dut_if.imm      = 64'h4;
    @(posedge clk); #1;
    @(negedge clk);
    chk("stall_no_out_valid", 64'(dut_if.out_valid), 64'd0);
    chk("stall_totcnt",       64'(dut_if.total_cnt), 64'd7);
    @(posedge clk); #1;
    dut_if.stall = 1'b0;
    push_exp(1'b0, 64'h6004, 1'b1, 32'd4, 32'd8);
    @(posedge clk); #1;
    dut_if.br_op = 3'b011;
    dut_if.pc    = 64'h7000;
    dut_if.imm   = 64'h0;
    push_exp(1'b0, 64'h7000, 1'b1, 32'd4, 32'd9);
    @(posedge clk); #1;
    dut_if.in_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("hold_illegal_pulse", 64'(dut_if.illegal),   64'd0);
    chk("hold_out_valid",     64'(dut_if.out_valid), 64'd0);
    chk("hold_taken",         64'(dut_if.taken),     64'd0);
    chk("hold_target",        dut_if.target,         64'h7000);
    chk("hold_in_ready",      64'(dut_if.in_ready),  64'd1);
    @(posedge clk); #1;

    // Reset in the first flush cycle.
    send(BNE, 64'h1, 64'h2, 64'h8000, 64'h20,
         1'b1, 64'h8020, 1'b0, 32'd5, 32'd10);
    dut_if.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_flush",     64'(dut_if.flush),     64'd0);
    chk("midrst_in_ready",  64'(dut_if.in_ready),  64'd1);
    chk("midrst_out_valid", 64'(dut_if.out_valid), 64'd0);
    chk("midrst_tkcnt",     64'(dut_if.taken_cnt), 64'd0);
    chk("midrst_totcnt",    64'(dut_if.total_cnt), 64'd0);
    @(posedge clk); #1;

    // Not-taken BEQ after reset: counters restart from zero.
    send(BEQ, 64'h1, 64'h2, 64'h9000, 64'h10,
         1'b0, 64'h9010, 1'b0, 32'd0, 32'd1);
    dut_if.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    chk("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
